// File: rtl/muler_seq_ctrl.sv
// -----------------------------------------------------------------------------
// muler_seq_ctrl
// Multi-cycle unsigned shift-add multiplier controller. It sits directly in
// front of an N-bit ALU: each CALC cycle it presents the partial-sum high half
// and (multiplicand or 0) to the ALU, then folds the ALU sum and carry back
// into a 2N-bit accumulator that shifts right one bit per cycle.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o, a_i, b_i      operand handshake (a=multiplicand)
//   out_valid_o/out_ready_i, prod_o      product handshake, prod_o = a*b
//   alu_a_o, alu_b_o, alu_sel_o          ALU operand/select drive
//   alu_s_i, alu_carry_i                 combinational ALU result
//   perf_cnt_o, busy_o                   only when MULER_PERF_EN is defined
//
// Build option: MULER_PERF_EN adds a 32-bit count of completed product
// handshakes (wrapping) and a busy flag (high in CALC or DONE).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for operands, ALU inputs held at zero
// CALC  | N shift-add iterations, one per clock
// DONE  | product valid, held until out_ready_i
// -----------------------------------------------------------------------------
module muler_seq_ctrl #(
    parameter int         N       = 4,
    parameter logic [2:0] ADD_SEL = 3'b000
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef MULER_PERF_EN
    output logic [31:0]    perf_cnt_o,
    output logic           busy_o,
`endif
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] prod_o,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic [2:0]     alu_sel_o,
    input  logic [N-1:0]   alu_s_i,
    input  logic           alu_carry_i
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        prod_o      = '0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                alu_a_o = acc[2*N-1:N];
                // Current multiplier bit decides whether this iteration adds.
                alu_b_o = acc[0] ? mcand : '0;
                if (cnt == CW'(N - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                prod_o      = acc;
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign alu_sel_o = ADD_SEL;
    assign accept    = (state == IDLE) && in_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            mcand <= a_i;
            acc   <= {{N{1'b0}}, b_i};
            cnt   <= '0;
        end else if (state == CALC) begin
            // Carry lands in the top bit, so the 2N-bit result never overflows.
            acc <= {alu_carry_i, alu_s_i, acc[N-1:1]};
            cnt <= cnt + CW'(1);
        end
    end

`ifdef MULER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_o <= '0;
        end else if (out_valid_o && out_ready_i) begin
            perf_cnt_o <= perf_cnt_o + 32'd1;
        end
    end

    assign busy_o = (state != IDLE);
`endif

endmodule

// File: tb/tb_muler_seq_ctrl.sv
module tb_muler_seq_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [N-1:0]   a_i = '0;
    logic [N-1:0]   b_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [2*N-1:0] prod_o;
    logic [N-1:0]   alu_a_o;
    logic [N-1:0]   alu_b_o;
    logic [2:0]     alu_sel_o;
    logic [N-1:0]   alu_s_i;
    logic           alu_carry_i;
`ifdef MULER_PERF_EN
    logic [31:0]    perf_cnt_o;
    logic           busy_o;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_perf = 0;

    always #5 clk = ~clk;

    // Reference ALU: unsigned add for select 000, garbage otherwise.
    logic [N:0] alu_res;
    assign alu_res = (alu_sel_o == 3'b000) ? ({1'b0, alu_a_o} + {1'b0, alu_b_o}) : '1;
    assign {alu_carry_i, alu_s_i} = alu_res;

    muler_seq_ctrl #(.N(N), .ADD_SEL(3'b000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MULER_PERF_EN
        .perf_cnt_o  (perf_cnt_o),
        .busy_o      (busy_o),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .prod_o      (prod_o),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_sel_o   (alu_sel_o),
        .alu_s_i     (alu_s_i),
        .alu_carry_i (alu_carry_i)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        int         stall;
        logic       need_carry;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                         input int stall, input logic need_carry);
        int cyc;
        int carry_seen;
        int bnz;
        int rdy_bad;
        carry_seen = 0;
        bnz = 0;
        rdy_bad = 0;
        @(negedge clk);
        check("idle_ready_alu", {in_ready_o, out_valid_o, alu_a_o, alu_b_o}, {1'b1, 1'b0, 8'h00});
`ifdef MULER_PERF_EN
        check("idle_busy", 32'(busy_o), 32'd0);
`endif
        in_valid_i  = 1'b1;
        a_i         = a;
        b_i         = b;
        out_ready_i = (stall == 0);
        @(negedge clk);
        in_valid_i = 1'b0;
        a_i = 4'h0;
        b_i = 4'h0;
        cyc = 1;
        while (!out_valid_o && cyc < 20) begin
            if (in_ready_o) rdy_bad++;
            if (alu_carry_i) carry_seen++;
            if (alu_b_o != 0) bnz++;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(N + 1));
        check("calc_ready_low", 32'(rdy_bad), 32'd0);
        check("alu_b_use", 32'(bnz > 0), 32'((a != 0) && (b != 0)));
        if (need_carry) check("carry_seen", 32'(carry_seen > 0), 32'd1);
        check("prod", 32'(prod_o), 32'(exp));
        check("done_ready_alu", {in_ready_o, alu_a_o, alu_b_o}, 9'h000);
`ifdef MULER_PERF_EN
        check("done_busy", 32'(busy_o), 32'd1);
`endif
        if (stall > 0) begin
            in_valid_i = 1'b1;
            a_i = 4'hF;
            b_i = 4'hF;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("stall_hold", {out_valid_o, in_ready_o, prod_o}, {1'b1, 1'b0, exp});
            end
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
        end
        @(negedge clk);
        exp_perf++;
        check("release_idle", {out_valid_o, in_ready_o, prod_o}, {1'b0, 1'b1, 8'h00});
`ifdef MULER_PERF_EN
        check("perf_cnt", perf_cnt_o, 32'(exp_perf));
`endif
    endtask

    initial begin
        int vld_seen;
        vecs[0]  = '{4'h5, 4'h7, 8'h23, 0, 1'b0};
        vecs[1]  = '{4'hF, 4'hF, 8'hE1, 0, 1'b1};
        vecs[2]  = '{4'h0, 4'hB, 8'h00, 0, 1'b0};
        vecs[3]  = '{4'h9, 4'h0, 8'h00, 0, 1'b0};
        vecs[4]  = '{4'h6, 4'h3, 8'h12, 5, 1'b0};
        vecs[5]  = '{4'hC, 4'hA, 8'h78, 0, 1'b0};
        vecs[6]  = '{4'h1, 4'hF, 8'h0F, 0, 1'b0};
        vecs[7]  = '{4'h8, 4'h8, 8'h40, 0, 1'b0};
        vecs[8]  = '{4'hF, 4'h1, 8'h0F, 0, 1'b0};
        vecs[9]  = '{4'hD, 4'hB, 8'h8F, 0, 1'b0};
        vecs[10] = '{4'h7, 4'h5, 8'h23, 2, 1'b0};
        vecs[11] = '{4'hF, 4'hE, 8'hD2, 0, 1'b0};

        #1;
        check("reset_state", {in_ready_o, out_valid_o, prod_o, alu_a_o, alu_b_o, alu_sel_o},
              {1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 3'b000});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].stall, vecs[i].need_carry);
        end

        // out_ready_i while idle must not disturb anything.
        out_ready_i = 1'b1;
        @(negedge clk);
        check("idle_out_ready", {in_ready_o, out_valid_o}, 2'b10);

        // Asynchronous reset in the middle of CALC.
        in_valid_i = 1'b1;
        a_i = 4'h7;
        b_i = 4'h5;
        @(negedge clk);
        in_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_perf = 0;
        check("async_reset", {in_ready_o, out_valid_o, prod_o, alu_a_o, alu_b_o},
              {1'b1, 1'b0, 8'h00, 4'h0, 4'h0});
`ifdef MULER_PERF_EN
        check("reset_perf", perf_cnt_o, 32'd0);
`endif
        vld_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            if (out_valid_o) vld_seen++;
        end
        check("no_valid_after_rst", 32'(vld_seen), 32'd0);
        do_op(4'h2, 4'h3, 8'h06, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
